// File: rtl/mini_src_pkg.sv
// Shared opcodes, ALU function codes, FSM states and strobe bundle for the
// mini SRC hardwired control unit.
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_JR, CLS_NOP, CLS_HALT, CLS_ILL
    } op_class_e;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out;
        logic c_out, con_in, read, write, gra, grb, grc, r_in, r_out, ba_out;
    } strobes_t;

    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI:                      return CLS_I;
            OP_LD:                                         return CLS_LD;
            OP_ST:                                         return CLS_ST;
            OP_BR:                                         return CLS_BR;
            OP_JR:                                         return CLS_JR;
            OP_NOP:                                        return CLS_NOP;
            OP_HALT:                                       return CLS_HALT;
            default:                                       return CLS_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_func(input logic [4:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mini_src_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/condition/memory status in, strobes out.
interface mini_src_control_unit_if #(
    parameter int ALU_OP_W = 4
);
    logic [31:0]         ir;
    logic                con_ff, mem_ready;
    logic                PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic                Cout, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [ALU_OP_W-1:0] alu_op;
    logic                run, illegal;
    logic [3:0]          step;

    modport master (
        input  ir, con_ff, mem_ready,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
               Cout, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
               alu_op, run, illegal, step
    );

    modport slave (
        output ir, con_ff, mem_ready,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
               Cout, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
               alu_op, run, illegal, step
    );
endinterface

// File: rtl/mini_src_control_unit_cu_output_decode.sv
// Combinational strobe decode from (state, opcode, con_ff); mem_ready only
// qualifies the PC load at the end of a fetch wait.
module cu_output_decode
    import mini_src_pkg::*;
(
    input  state_e     state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_ready,
    output strobes_t   strobes,
    output logic [3:0] alu_code,
    output logic       illegal
);
    op_class_e cls;
    assign cls = op_class(opcode);

    always_comb begin
        strobes  = '0;
        alu_code = ALU_ADD;
        illegal  = 1'b0;
        case (state)
            S_T0: begin
                strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
            end
            S_T1: begin
                strobes.zlow_out = 1'b1; strobes.read = 1'b1; strobes.mdr_in = 1'b1;
                // PC loads only on the cycle the fetch completes, so it advances once.
                strobes.pc_in = mem_ready;
            end
            S_T2: begin
                strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_R, CLS_I: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
                    end
                    CLS_ILL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_R: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1;
                        alu_code = alu_func(opcode);
                    end
                    CLS_I: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1;
                        alu_code = alu_func(opcode);
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_R, CLS_I: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD: begin
                        strobes.read = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes.zlow_out = con_ff; strobes.pc_in = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CLS_ST:  strobes.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired control FSM for the single-bus SRC datapath: state register and
// sequencing here, strobe decode in cu_output_decode.
//   state | meaning
//   IDLE  | out of reset, no strobes
//   T0-T2 | fetch (T1 waits on mem_ready)
//   T3-T7 | execute steps (ld waits in T6, st waits in T7)
//   HALT  | stopped until reset
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input logic                     clk,
    input logic                     reset_n,
    mini_src_control_unit_if.master bus
);
    state_e     state_q, state_d;
    op_class_e  cls;
    strobes_t   strobes;
    logic [3:0] alu_code;
    logic       unused_ir;

    assign cls       = op_class(bus.ir[31:27]);
    assign unused_ir = ^bus.ir[26:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2: begin
                if (cls == CLS_NOP)       state_d = S_T0;
                else if (cls == CLS_HALT) state_d = S_HALT;
                else                      state_d = S_T3;
            end
            S_T3: state_d = (cls == CLS_JR || cls == CLS_ILL) ? S_T0 : S_T4;
            S_T4: state_d = S_T5;
            S_T5: state_d = (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) ? S_T6 : S_T0;
            S_T6: begin
                if (cls == CLS_LD)      state_d = bus.mem_ready ? S_T7 : S_T6;
                else if (cls == CLS_ST) state_d = S_T7;
                else                    state_d = S_T0;
            end
            S_T7: begin
                if (cls != CLS_ST || bus.mem_ready) state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    cu_output_decode u_decode (
        .state     (state_q),
        .opcode    (bus.ir[31:27]),
        .con_ff    (bus.con_ff),
        .mem_ready (bus.mem_ready),
        .strobes   (strobes),
        .alu_code  (alu_code),
        .illegal   (bus.illegal)
    );

    assign bus.PCout   = strobes.pc_out;
    assign bus.PCin    = strobes.pc_in;
    assign bus.IncPC   = strobes.inc_pc;
    assign bus.MARin   = strobes.mar_in;
    assign bus.MDRin   = strobes.mdr_in;
    assign bus.MDRout  = strobes.mdr_out;
    assign bus.IRin    = strobes.ir_in;
    assign bus.Yin     = strobes.y_in;
    assign bus.Zin     = strobes.z_in;
    assign bus.Zlowout = strobes.zlow_out;
    assign bus.Cout    = strobes.c_out;
    assign bus.CONin   = strobes.con_in;
    assign bus.Read    = strobes.read;
    assign bus.Write   = strobes.write;
    assign bus.Gra     = strobes.gra;
    assign bus.Grb     = strobes.grb;
    assign bus.Grc     = strobes.grc;
    assign bus.Rin     = strobes.r_in;
    assign bus.Rout    = strobes.r_out;
    assign bus.BAout   = strobes.ba_out;
    assign bus.alu_op  = ALU_OP_W'(alu_code);
    assign bus.run     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.step    = state_q;
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench: per-cycle expected step/strobes are queued with stimulus
// and compared one cycle at a time.
module tb_mini_src_control_unit;
    import mini_src_pkg::*;

    localparam logic [19:0] M_PCOUT   = 20'h80000, M_PCIN   = 20'h40000, M_INCPC = 20'h20000;
    localparam logic [19:0] M_MARIN   = 20'h10000, M_MDRIN  = 20'h08000, M_MDROUT = 20'h04000;
    localparam logic [19:0] M_IRIN    = 20'h02000, M_YIN    = 20'h01000, M_ZIN   = 20'h00800;
    localparam logic [19:0] M_ZLOWOUT = 20'h00400, M_COUT   = 20'h00200, M_CONIN = 20'h00100;
    localparam logic [19:0] M_READ    = 20'h00080, M_WRITE  = 20'h00040, M_GRA   = 20'h00020;
    localparam logic [19:0] M_GRB     = 20'h00010, M_GRC    = 20'h00008, M_RIN   = 20'h00004;
    localparam logic [19:0] M_ROUT    = 20'h00002, M_BAOUT  = 20'h00001;

    typedef struct packed { logic [31:0] ir; logic mr; logic cf; } stim_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_inc = 0;
    int          n_pcin = 0;
    logic [29:0] exp_q[$];
    stim_t       stim_q[$];

    mini_src_control_unit_if #(.ALU_OP_W(4)) bus ();
    mini_src_control_unit #(.ALU_OP_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic [29:0] observe();
        return {bus.step, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Cout, bus.CONin, bus.Read,
                bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                bus.alu_op, bus.illegal, bus.run};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [31:0] ir, input state_e st, input logic [19:0] s,
                        input logic [3:0] alu, input logic ill, input logic mr, input logic cf);
        logic run;
        run = (st != S_IDLE) && (st != S_HALT);
        exp_q.push_back({4'(st), s, alu, ill, run});
        stim_q.push_back({ir, mr, cf});
    endtask

    task automatic push_insn(input logic [31:0] ir, input int fw, input int mw, input logic cf);
        logic [4:0] op;
        logic [3:0] f;
        op = ir[31:27];
        f  = 4'd0;
        case (op)
            5'b00100:           f = 4'd1;
            5'b00101, 5'b01101: f = 4'd2;
            5'b00110, 5'b01110: f = 4'd3;
            5'b00111:           f = 4'd4;
            5'b01001:           f = 4'd5;
            default:            f = 4'd0;
        endcase
        push(ir, S_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0, rb(), rb());
        for (int i = 0; i < fw; i++)
            push(ir, S_T1, M_ZLOWOUT | M_READ | M_MDRIN, 4'd0, 1'b0, 1'b0, rb());
        push(ir, S_T1, M_ZLOWOUT | M_READ | M_MDRIN | M_PCIN, 4'd0, 1'b0, 1'b1, rb());
        push(ir, S_T2, M_MDROUT | M_IRIN, 4'd0, 1'b0, rb(), rb());
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001: begin
                push(ir, S_T3, M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, rb(), rb());
                push(ir, S_T4, M_GRC | M_ROUT | M_ZIN, f, 1'b0, rb(), rb());
                push(ir, S_T5, M_ZLOWOUT | M_GRA | M_RIN, 4'd0, 1'b0, rb(), rb());
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(ir, S_T3, M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, rb(), rb());
                push(ir, S_T4, M_COUT | M_ZIN, f, 1'b0, rb(), rb());
                push(ir, S_T5, M_ZLOWOUT | M_GRA | M_RIN, 4'd0, 1'b0, rb(), rb());
            end
            5'b00000, 5'b00010: begin
                push(ir, S_T3, M_GRB | M_BAOUT | M_YIN, 4'd0, 1'b0, rb(), rb());
                push(ir, S_T4, M_COUT | M_ZIN, 4'd0, 1'b0, rb(), rb());
                push(ir, S_T5, M_ZLOWOUT | M_MARIN, 4'd0, 1'b0, rb(), rb());
                if (op == 5'b00000) begin
                    for (int i = 0; i < mw; i++)
                        push(ir, S_T6, M_READ | M_MDRIN, 4'd0, 1'b0, 1'b0, rb());
                    push(ir, S_T6, M_READ | M_MDRIN, 4'd0, 1'b0, 1'b1, rb());
                    push(ir, S_T7, M_MDROUT | M_GRA | M_RIN, 4'd0, 1'b0, rb(), rb());
                end else begin
                    push(ir, S_T6, M_GRA | M_ROUT | M_MDRIN, 4'd0, 1'b0, rb(), rb());
                    for (int i = 0; i < mw; i++)
                        push(ir, S_T7, M_WRITE, 4'd0, 1'b0, 1'b0, rb());
                    push(ir, S_T7, M_WRITE, 4'd0, 1'b0, 1'b1, rb());
                end
            end
            5'b10010: begin
                push(ir, S_T3, M_GRA | M_ROUT | M_CONIN, 4'd0, 1'b0, rb(), !cf);
                push(ir, S_T4, M_PCOUT | M_YIN, 4'd0, 1'b0, rb(), !cf);
                push(ir, S_T5, M_COUT | M_ZIN, 4'd0, 1'b0, rb(), !cf);
                push(ir, S_T6, cf ? (M_ZLOWOUT | M_PCIN) : 20'h0, 4'd0, 1'b0, rb(), cf);
            end
            5'b10100: push(ir, S_T3, M_GRA | M_ROUT | M_PCIN, 4'd0, 1'b0, rb(), rb());
            5'b11010: ;
            5'b11011: begin
                for (int i = 0; i < 20; i++)
                    push(ir, S_HALT, 20'h0, 4'd0, 1'b0, rb(), rb());
            end
            default: push(ir, S_T3, 20'h0, 4'd0, 1'b1, rb(), rb());
        endcase
    endtask

    // n < 0 drains the whole queue; entered and left at posedge+1.
    task automatic drain(input int n);
        stim_t       s;
        logic [29:0] e;
        logic [2:0]  ex;
        int          k;
        k = 0;
        while (exp_q.size() != 0 && (n < 0 || k < n)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            bus.ir = s.ir;
            bus.mem_ready = s.mr;
            bus.con_ff = s.cf;
            #1;
            check_val($sformatf("cycle%0d", cyc), 32'(observe()), 32'(e));
            ex = {($countones({bus.Gra, bus.Grb, bus.Grc}) <= 1),
                  !(bus.Rin && bus.Rout), !(bus.Read && bus.Write)};
            check_val("excl", 32'(ex), 32'd7);
            if (e[29:26] == 4'(S_T0)) begin
                n_inc = 0;
                n_pcin = 0;
            end
            if (e[29:26] == 4'(S_T0) || e[29:26] == 4'(S_T1) || e[29:26] == 4'(S_T2)) begin
                n_inc  += int'(bus.IncPC);
                n_pcin += int'(bus.PCin);
            end
            if (e[29:26] == 4'(S_T2)) begin
                check_val("fetch_incpc", n_inc, 1);
                check_val("fetch_pcin", n_pcin, 1);
            end
            cyc++;
            k++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ir = '0;
        bus.mem_ready = 1'b0;
        bus.con_ff = 1'b0;
        @(posedge clk);
        #1;
        check_val("reset_state", 32'(observe()), 32'({4'(S_IDLE), 26'd0}));
        @(posedge clk);
        #1;
        check_val("reset_hold", 32'(observe()), 32'({4'(S_IDLE), 26'd0}));
        reset_n = 1'b1;

        push(32'h0, S_IDLE, 20'h0, 4'd0, 1'b0, rb(), rb());
        push_insn(32'h18918000, 0, 0, 1'b0);
        push_insn(32'h20000000, 0, 0, 1'b0);
        push_insn(32'h28000000, 0, 0, 1'b0);
        push_insn(32'h30000000, 0, 0, 1'b0);
        push_insn(32'h38000000, 0, 0, 1'b0);
        push_insn(32'h48000000, 0, 0, 1'b0);
        push_insn(32'h60000000, 0, 0, 1'b0);
        push_insn(32'h68000000, 0, 0, 1'b0);
        push_insn(32'h70000000, 0, 0, 1'b0);
        push_insn(32'h00900055, 0, 3, 1'b0);
        push_insn(32'h10000000, 0, 2, 1'b0);
        push_insn(32'h92000010, 0, 0, 1'b1);
        push_insn(32'h92000010, 0, 0, 1'b0);
        push_insn(32'hA0000000, 0, 0, 1'b0);
        push_insn(32'hD0000000, 0, 0, 1'b0);
        push_insn(32'h18918000, 2, 0, 1'b0);
        push_insn(32'h08000000, 0, 0, 1'b0);
        push_insn(32'hD8000000, 0, 0, 1'b0);
        drain(-1);

        reset_n = 1'b0;
        #1;
        check_val("halt_reset_step", 32'(bus.step), 32'(S_IDLE));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        push_insn(32'h10000000, 0, 3, 1'b0);
        drain(8);
        bus.mem_ready = 1'b0;
        #1;
        check_val("abort_write_pre", 32'(bus.Write), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("abort_write", 32'(bus.Write), 32'd0);
        check_val("abort_all", 32'(observe()), 32'({4'(S_IDLE), 26'd0}));
        exp_q.delete();
        stim_q.delete();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        push_insn(32'hF8000000, 0, 0, 1'b0);
        push_insn(32'h18918000, 1, 0, 1'b0);
        drain(-1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
